// File: rtl/grid_checker.sv
// Sudoku grid checker: consumes a row-major stream of one-hot cells and flags any repeated symbol in a row, column or block.
// Optional GRID_CHECKER_ERRPOS_EN adds err_row/err_col, which hold the position of the first bad beat.
module grid_checker #(
    parameter int ORD = 3,
    parameter int LEN = ORD * ORD
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [LEN-1:0]            in_data,
    output logic                      in_ready,
    output logic                      done,
    output logic                      success
`ifdef GRID_CHECKER_ERRPOS_EN
    ,
    output logic [$clog2(LEN)-1:0]    err_row,
    output logic [$clog2(LEN)-1:0]    err_col
`endif
);
    localparam int CW = $clog2(LEN);
    localparam int BW = (ORD > 1) ? $clog2(ORD) : 1;

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             row_q, row_d, col_q, col_d;
    logic [LEN-1:0]            row_seen_q, row_seen_d;
    logic [LEN-1:0][LEN-1:0]   col_seen_q, col_seen_d;
    logic [ORD-1:0][LEN-1:0]   blk_seen_q, blk_seen_d;
    logic                      err_q, err_d;
    logic                      in_ready_q, in_ready_d;
    logic                      done_q, done_d;
    logic                      success_q, success_d;
`ifdef GRID_CHECKER_ERRPOS_EN
    logic [CW-1:0]             err_row_q, err_row_d, err_col_q, err_col_d;
`endif

    logic          accept, not_onehot, beat_err, col_last, row_last, blk_row_last;
    logic [BW-1:0] bc;

    assign accept       = in_valid && in_ready_q;
    assign bc           = BW'(col_q / CW'(ORD));
    assign col_last     = (col_q == CW'(LEN - 1));
    assign row_last     = (row_q == CW'(LEN - 1));
    assign blk_row_last = ((row_q % CW'(ORD)) == CW'(ORD - 1));
    assign not_onehot   = (in_data == '0) || ((in_data & (in_data - LEN'(1))) != '0);
    assign beat_err     = not_onehot
                        || ((in_data & row_seen_q) != '0)
                        || ((in_data & col_seen_q[col_q]) != '0)
                        || ((in_data & blk_seen_q[bc]) != '0);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        row_seen_d = row_seen_q;
        col_seen_d = col_seen_q;
        blk_seen_d = blk_seen_q;
        err_d      = err_q;
        in_ready_d = in_ready_q;
        done_d     = done_q;
        success_d  = success_q;
`ifdef GRID_CHECKER_ERRPOS_EN
        err_row_d  = err_row_q;
        err_col_d  = err_col_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RECV;
                    in_ready_d = 1'b1;
                    done_d     = 1'b0;
                    success_d  = 1'b0;
                    row_d      = '0;
                    col_d      = '0;
                    row_seen_d = '0;
                    col_seen_d = '0;
                    blk_seen_d = '0;
                    err_d      = 1'b0;
`ifdef GRID_CHECKER_ERRPOS_EN
                    err_row_d  = '0;
                    err_col_d  = '0;
`endif
                end
            end
            RECV: begin
                if (accept) begin
                    err_d = err_q | beat_err;
`ifdef GRID_CHECKER_ERRPOS_EN
                    if (beat_err && !err_q) begin
                        err_row_d = row_q;
                        err_col_d = col_q;
                    end
`endif
                    // Masks accumulate even on error; checking continues to the end of the grid.
                    row_seen_d         = row_seen_q | in_data;
                    col_seen_d[col_q]  = col_seen_q[col_q] | in_data;
                    blk_seen_d[bc]     = blk_seen_q[bc] | in_data;
                    col_d              = col_q + CW'(1);
                    if (col_last) begin
                        col_d      = '0;
                        row_d      = row_last ? '0 : row_q + CW'(1);
                        row_seen_d = '0;
                        if (blk_row_last) blk_seen_d = '0;
                    end
                    if (col_last && row_last) begin
                        state_d    = DONE;
                        in_ready_d = 1'b0;
                        done_d     = 1'b1;
                        success_d  = !(err_q | beat_err);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            row_seen_q <= '0;
            col_seen_q <= '0;
            blk_seen_q <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            success_q  <= 1'b0;
`ifdef GRID_CHECKER_ERRPOS_EN
            err_row_q  <= '0;
            err_col_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_seen_q <= row_seen_d;
            col_seen_q <= col_seen_d;
            blk_seen_q <= blk_seen_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            success_q  <= success_d;
`ifdef GRID_CHECKER_ERRPOS_EN
            err_row_q  <= err_row_d;
            err_col_q  <= err_col_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign done     = done_q;
    assign success  = success_q;
`ifdef GRID_CHECKER_ERRPOS_EN
    assign err_row  = err_row_q;
    assign err_col  = err_col_q;
`endif
endmodule

// File: tb/tb_grid_checker.sv
// Directed bench for grid_checker at ORD=2: table of whole-grid runs plus reset/restart sequences.
module tb_grid_checker;
    typedef logic [15:0][3:0] cells_t;
    typedef struct {
        string  name;
        cells_t cells;
        bit     gappy;
        bit     exp_succ;
        int     exp_row;
        int     exp_col;
    } vec_t;

    logic       clock, reset, start, in_valid;
    logic [3:0] in_data;
    logic       in_ready, done, success;
`ifdef GRID_CHECKER_ERRPOS_EN
    logic [1:0] err_row, err_col;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs[7];

    grid_checker #(.ORD(2), .LEN(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .done     (done),
        .success  (success)
`ifdef GRID_CHECKER_ERRPOS_EN
        ,
        .err_row  (err_row),
        .err_col  (err_col)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [3:0] enc(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return (d >= 1 && d <= 4) ? (one << (d - 1)) : 4'b0000;
    endfunction

    // Each row is given as four decimal digits, leftmost digit = column 0.
    function automatic cells_t grid(input int r0, input int r1, input int r2, input int r3);
        cells_t c;
        int rows[4];
        int pw[4];
        rows = '{r0, r1, r2, r3};
        pw   = '{1000, 100, 10, 1};
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                c[r*4 + k] = enc((rows[r] / pw[k]) % 10);
        return c;
    endfunction

    function automatic vec_t mk(input string n, input cells_t c, input bit g, input bit s,
                                input int er, input int ec);
        vec_t v;
        v.name = n; v.cells = c; v.gappy = g; v.exp_succ = s; v.exp_row = er; v.exp_col = ec;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int beat, cyc, ready_low, early_done;
        bit vld;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        chk({v.name, "_start_ready"}, in_ready, 1);
        chk({v.name, "_start_done"}, done, 0);
        beat = 0; cyc = 0; ready_low = 0; early_done = 0;
        while (beat < 16 && cyc < 200) begin
            @(negedge clock);
            start    = 1'b0;
            vld      = v.gappy ? (cyc % 3 == 0) : 1'b1;
            in_valid = vld;
            in_data  = v.cells[beat];
            if (!in_ready) ready_low++;
            if (done) early_done++;
            if (vld && in_ready) beat++;
            cyc++;
        end
        chk({v.name, "_beats"}, beat, 16);
        chk({v.name, "_cycles"}, cyc, v.gappy ? 46 : 16);
        chk({v.name, "_ready_gaps"}, ready_low, 0);
        chk({v.name, "_early_done"}, early_done, 0);
        @(negedge clock);
        in_valid = 1'b0;
        chk({v.name, "_done"}, done, 1);
        chk({v.name, "_success"}, success, v.exp_succ);
        chk({v.name, "_ready_after"}, in_ready, 0);
`ifdef GRID_CHECKER_ERRPOS_EN
        chk({v.name, "_err_row"}, err_row, v.exp_row);
        chk({v.name, "_err_col"}, err_col, v.exp_col);
`endif
    endtask

    initial begin
        cells_t good, c;
        good = grid(1234, 3412, 2143, 4321);
        vecs[0] = mk("valid", good, 0, 1, 0, 0);
        vecs[1] = mk("rowdup", grid(1231, 3412, 2143, 4321), 0, 0, 0, 3);
        vecs[2] = mk("latin", grid(1234, 2341, 3412, 4123), 0, 0, 1, 0);
        c = good; c[9] = 4'b0000;
        vecs[3] = mk("zero_cell", c, 0, 0, 2, 1);
        c = good; c[9] = 4'b0011;
        vecs[4] = mk("multi_hot", c, 0, 0, 2, 1);
        vecs[5] = mk("gappy", good, 1, 1, 0, 0);
        vecs[6] = mk("restart", good, 0, 1, 0, 0);

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_success", success, 0);
        @(negedge clock);
        chk("idle_no_start_ready", in_ready, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Abort a run after 7 beats with reset, then check a clean grid still passes.
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = good[i];
            @(negedge clock);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_ready", in_ready, 0);
        chk("midrst_done", done, 0);
        chk("midrst_success", success, 0);
        repeat (2) @(negedge clock);
        chk("midrst_idle_ready", in_ready, 0);
        run_vec(mk("post_reset", good, 0, 1, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
